lsu_mem_port_arbiter: RTL and testbench

- Sequences the single LSU cache/memory execute port between two requesters:
  - fresh load/store packets from AGEN;
  - load replays queued by the load queue after a predicted violation or miss.
- Buffers replays in a small FIFO and registers the winning packet for LDX/STX.
- Prevents replay starvation with an age counter and an AGEN stall request.
- Flushes all queued state on recovery.

---
 rtl/lsu_mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port_arbiter.sv
// Arbitrates the single LSU execute port between fresh AGEN packets and queued
// load replays. Replays wait in a small circular FIFO. An age counter raises an
// AGEN stall request so that a waiting replay is always granted eventually.
module lsu_mem_port_arbiter #(
  parameter int unsigned PKT_W        = 96,
  parameter int unsigned REPLAY_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            recoverFlag_i,
  input  logic                            agenValid_i,
  input  logic                            agenIsLoad_i,
  input  logic [PKT_W-1:0]                agenPkt_i,
  output logic                            agenStall_o,
  input  logic                            replayValid_i,
  input  logic [PKT_W-1:0]                replayPkt_i,
  output logic                            replayFull_o,
  output logic [$clog2(REPLAY_DEPTH):0]   replayCount_o,
  output logic                            replayOverflow_o,
  output logic                            portValid_o,
  output logic                            portIsLoad_o,
  output logic [1:0]                      portSrc_o,
  output logic [PKT_W-1:0]                portPkt_o
);

  localparam int unsigned PtrW = $clog2(REPLAY_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] SrcNone   = 2'b00;
  localparam logic [1:0] SrcAgen   = 2'b01;
  localparam logic [1:0] SrcReplay = 2'b10;

  logic [PKT_W-1:0] mem_q [REPLAY_DEPTH];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [StW-1:0]   starve_q, starve_d;
  logic             ovf_q, ovf_d;

  logic             port_valid_q, port_valid_d;
  logic             port_is_load_q, port_is_load_d;
  logic [1:0]       port_src_q, port_src_d;
  logic [PKT_W-1:0] port_pkt_q, port_pkt_d;

  logic fifo_empty, fifo_full, enq, deq;

  // Grant decision, FIFO bookkeeping and starvation tracking for this cycle.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(REPLAY_DEPTH));

    // Only entries already resident can be dequeued: no same-cycle bypass.
    deq = !recoverFlag_i && !agenValid_i && !fifo_empty;
    // At full, an enqueue is accepted only if a slot frees up in the same cycle.
    enq = !recoverFlag_i && replayValid_i && (!fifo_full || deq);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (replayValid_i && !recoverFlag_i && fifo_full && !deq) begin
      ovf_d = 1'b1;
    end
    if (enq) begin
      tail_d = tail_q + 1'b1;
    end
    if (deq) begin
      head_d = head_q + 1'b1;
    end
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (!enq && deq) begin
      count_d = count_q - 1'b1;
    end

    starve_d = starve_q;
    if (fifo_empty || deq) begin
      starve_d = '0;
    end else if (agenValid_i && (starve_q != StW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    port_valid_d   = 1'b0;
    port_is_load_d = 1'b0;
    port_src_d     = SrcNone;
    port_pkt_d     = '0;
    if (!recoverFlag_i) begin
      if (agenValid_i) begin
        port_valid_d   = 1'b1;
        port_is_load_d = agenIsLoad_i;
        port_src_d     = SrcAgen;
        port_pkt_d     = agenPkt_i;
      end else if (deq) begin
        port_valid_d   = 1'b1;
        port_is_load_d = 1'b1;
        port_src_d     = SrcReplay;
        port_pkt_d     = mem_q[head_q];
      end
    end

    // Recovery drops everything queued and rewinds both pointers.
    if (recoverFlag_i) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      starve_d = '0;
    end
  end

  // Control state and registered port outputs; reset wins over recovery.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      starve_q       <= '0;
      ovf_q          <= 1'b0;
      port_valid_q   <= 1'b0;
      port_is_load_q <= 1'b0;
      port_src_q     <= SrcNone;
      port_pkt_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      starve_q       <= starve_d;
      ovf_q          <= ovf_d;
      port_valid_q   <= port_valid_d;
      port_is_load_q <= port_is_load_d;
      port_src_q     <= port_src_d;
      port_pkt_q     <= port_pkt_d;
    end
  end

  // Replay payload storage; contents are don't-care while the slot is free.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem_q[tail_q] <= replayPkt_i;
    end
  end

  assign agenStall_o      = (starve_q == StW'(STARVE_LIMIT)) && (count_q != '0);
  assign replayFull_o     = (count_q == CntW'(REPLAY_DEPTH));
  assign replayCount_o    = count_q;
  assign replayOverflow_o = ovf_q;
  assign portValid_o      = port_valid_q;
  assign portIsLoad_o     = port_is_load_q;
  assign portSrc_o        = port_src_q;
  assign portPkt_o        = port_pkt_q;

endmodule

// File: tb/tb_lsu_mem_port_arbiter.sv
// Directed bench for lsu_mem_port_arbiter with hand-computed expectations.
module tb_lsu_mem_port_arbiter;

  localparam int unsigned PKT_W = 96;

  logic             clk = 1'b0;
  logic             reset;
  logic             recoverFlag_i;
  logic             agenValid_i;
  logic             agenIsLoad_i;
  logic [PKT_W-1:0] agenPkt_i;
  logic             agenStall_o;
  logic             replayValid_i;
  logic [PKT_W-1:0] replayPkt_i;
  logic             replayFull_o;
  logic [2:0]       replayCount_o;
  logic             replayOverflow_o;
  logic             portValid_o;
  logic             portIsLoad_o;
  logic [1:0]       portSrc_o;
  logic [PKT_W-1:0] portPkt_o;

  int checks = 0;
  int errors = 0;

  lsu_mem_port_arbiter #(
    .PKT_W       (PKT_W),
    .REPLAY_DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .recoverFlag_i   (recoverFlag_i),
    .agenValid_i     (agenValid_i),
    .agenIsLoad_i    (agenIsLoad_i),
    .agenPkt_i       (agenPkt_i),
    .agenStall_o     (agenStall_o),
    .replayValid_i   (replayValid_i),
    .replayPkt_i     (replayPkt_i),
    .replayFull_o    (replayFull_o),
    .replayCount_o   (replayCount_o),
    .replayOverflow_o(replayOverflow_o),
    .portValid_o     (portValid_o),
    .portIsLoad_o    (portIsLoad_o),
    .portSrc_o       (portSrc_o),
    .portPkt_o       (portPkt_o)
  );

  always #5 clk = ~clk;

  // AGEN must not present a packet while a stall is requested.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(agenValid_i && agenStall_o)) else begin
        errors++;
        $error("FAIL agen_while_stall observed=1 expected=0");
      end
    end
  end

  function automatic logic [PKT_W-1:0] mk(input logic [31:0] x);
    return {x, ~x, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic v, input logic ld, input logic [1:0] src,
                          input logic [PKT_W-1:0] pkt);
    chk({tag, "_valid"}, 128'(portValid_o), 128'(v));
    chk({tag, "_isload"}, 128'(portIsLoad_o), 128'(ld));
    chk({tag, "_src"}, 128'(portSrc_o), 128'(src));
    chk({tag, "_pkt"}, 128'(portPkt_o), 128'(pkt));
  endtask

  task automatic idle();
    agenValid_i   = 1'b0;
    agenIsLoad_i  = 1'b0;
    agenPkt_i     = '0;
    replayValid_i = 1'b0;
    replayPkt_i   = '0;
    recoverFlag_i = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset / idle: everything zero for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_port("idle", 1'b0, 1'b0, 2'b00, '0);
      chk("idle_count", 128'(replayCount_o), 128'(0));
      chk("idle_full", 128'(replayFull_o), 128'(0));
      chk("idle_stall", 128'(agenStall_o), 128'(0));
      chk("idle_ovf", 128'(replayOverflow_o), 128'(0));
    end

    // Single replay with no AGEN traffic: granted the cycle after it lands.
    replayValid_i = 1'b1;
    replayPkt_i   = mk(32'hA);
    tick();
    idle();
    chk("a_count1", 128'(replayCount_o), 128'(1));
    chk("a_notyet", 128'(portValid_o), 128'(0));
    tick();
    chk_port("a_grant", 1'b1, 1'b1, 2'b10, mk(32'hA));
    chk("a_count0", 128'(replayCount_o), 128'(0));

    // Three replays queued under continuous AGEN; starvation builds to the limit.
    agenValid_i  = 1'b1;
    agenIsLoad_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      agenPkt_i     = mk(32'h100 + i);
      replayValid_i = 1'b1;
      replayPkt_i   = mk(32'h200 + i);
      tick();
    end
    replayValid_i = 1'b0;
    chk_port("s_agen", 1'b1, 1'b1, 2'b01, mk(32'h102));
    chk("s_count3", 128'(replayCount_o), 128'(3));
    for (int i = 0; i < 5; i++) begin
      agenPkt_i = mk(32'h110 + i);
      tick();
    end
    chk("s_stall_before", 128'(agenStall_o), 128'(0));
    agenPkt_i = mk(32'h120);
    tick();
    chk("s_stall_rise", 128'(agenStall_o), 128'(1));
    idle();
    tick();
    chk_port("s_replay", 1'b1, 1'b1, 2'b10, mk(32'h200));
    chk("s_count2", 128'(replayCount_o), 128'(2));
    chk("s_stall_fall", 128'(agenStall_o), 128'(0));
    chk("s_starve0", 128'(dut.starve_q), 128'(0));
    tick();
    chk_port("s_drain1", 1'b1, 1'b1, 2'b10, mk(32'h201));
    tick();
    chk_port("s_drain2", 1'b1, 1'b1, 2'b10, mk(32'h202));
    chk("s_empty", 128'(replayCount_o), 128'(0));

    // Fill to full behind AGEN, overflow, then enqueue+dequeue at full with wrap.
    agenValid_i  = 1'b1;
    agenIsLoad_i = 1'b0;
    agenPkt_i    = mk(32'h300);
    for (int i = 0; i < 4; i++) begin
      replayValid_i = 1'b1;
      replayPkt_i   = mk(32'h400 + i);
      tick();
    end
    chk("f_count4", 128'(replayCount_o), 128'(4));
    chk("f_full", 128'(replayFull_o), 128'(1));
    chk("f_ovf_pre", 128'(replayOverflow_o), 128'(0));
    replayPkt_i = mk(32'h4FF);
    tick();
    chk("f_ovf", 128'(replayOverflow_o), 128'(1));
    chk("f_count_ovf", 128'(replayCount_o), 128'(4));
    agenValid_i = 1'b0;
    replayPkt_i = mk(32'h405);
    tick();
    chk_port("f_ed0", 1'b1, 1'b1, 2'b10, mk(32'h400));
    chk("f_ed0_count", 128'(replayCount_o), 128'(4));
    replayPkt_i = mk(32'h406);
    tick();
    chk_port("f_ed1", 1'b1, 1'b1, 2'b10, mk(32'h401));
    chk("f_ed1_count", 128'(replayCount_o), 128'(4));
    idle();
    tick();
    chk_port("f_d2", 1'b1, 1'b1, 2'b10, mk(32'h402));
    tick();
    chk_port("f_d3", 1'b1, 1'b1, 2'b10, mk(32'h403));
    tick();
    chk_port("f_wrap5", 1'b1, 1'b1, 2'b10, mk(32'h405));
    tick();
    chk_port("f_wrap6", 1'b1, 1'b1, 2'b10, mk(32'h406));
    chk("f_count0", 128'(replayCount_o), 128'(0));
    chk("f_ovf_sticky", 128'(replayOverflow_o), 128'(1));

    // Recovery with 3 queued and AGEN busy: flush everything in one edge.
    agenValid_i  = 1'b1;
    agenIsLoad_i = 1'b1;
    agenPkt_i    = mk(32'h500);
    for (int i = 0; i < 3; i++) begin
      replayValid_i = 1'b1;
      replayPkt_i   = mk(32'h600 + i);
      tick();
    end
    chk("r_count3", 128'(replayCount_o), 128'(3));
    recoverFlag_i = 1'b1;
    replayPkt_i   = mk(32'h6FF);
    tick();
    idle();
    chk_port("r_flush", 1'b0, 1'b0, 2'b00, '0);
    chk("r_count0", 128'(replayCount_o), 128'(0));
    chk("r_starve0", 128'(dut.starve_q), 128'(0));
    chk("r_stall0", 128'(agenStall_o), 128'(0));
    chk("r_ovf_kept", 128'(replayOverflow_o), 128'(1));
    replayValid_i = 1'b1;
    replayPkt_i   = mk(32'h700);
    tick();
    replayPkt_i = mk(32'h701);
    tick();
    idle();
    chk_port("r_new0", 1'b1, 1'b1, 2'b10, mk(32'h700));
    tick();
    chk_port("r_new1", 1'b1, 1'b1, 2'b10, mk(32'h701));

    // AGEN store and replay in the same cycle: AGEN first, replay next idle cycle.
    tick();
    agenValid_i   = 1'b1;
    agenIsLoad_i  = 1'b0;
    agenPkt_i     = mk(32'h800);
    replayValid_i = 1'b1;
    replayPkt_i   = mk(32'h900);
    tick();
    idle();
    chk_port("c_agen", 1'b1, 1'b0, 2'b01, mk(32'h800));
    tick();
    chk_port("c_replay", 1'b1, 1'b1, 2'b10, mk(32'h900));

    // Reset mid-operation beats a concurrent recovery and clears the sticky flag.
    agenValid_i   = 1'b1;
    agenPkt_i     = mk(32'hA00);
    replayValid_i = 1'b1;
    replayPkt_i   = mk(32'hB00);
    tick();
    chk("x_count1", 128'(replayCount_o), 128'(1));
    reset         = 1'b1;
    recoverFlag_i = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk_port("x_reset", 1'b0, 1'b0, 2'b00, '0);
    chk("x_count0", 128'(replayCount_o), 128'(0));
    chk("x_ovf0", 128'(replayOverflow_o), 128'(0));
    tick();
    chk("x_still_idle", 128'(portValid_o), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
